m_copy_engine: RTL and testbench

//  Module-side engine of a compression-unit channel. Pops 65-bit words (64 data + last) from the

---
 rtl/m_copy_pkg.sv | 24 ++
 rtl/m_copy_if.sv | 24 ++
 rtl/m_copy_skid.sv | 62 ++++++
 rtl/m_copy_engine.sv | 122 ++++++++++++
 tb/tb_m_copy_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/m_copy_pkg.sv
// Shared types and helpers for the copy engine: FSM encoding, word layout, byte swap.
package m_copy_pkg;

  localparam int WORD_W   = 64;
  localparam int LAST_BIT = 64;
  localparam int ENTRY_W  = WORD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] bswap64(input logic [WORD_W-1:0] d);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/m_copy_if.sv
// Channel FIFO bus seen by the copy engine: source-FIFO read side and destination-FIFO write side.
interface m_copy_if;
  import m_copy_pkg::*;

  logic [WORD_W-1:0] m_src;
  logic              m_src_last;
  logic              m_src_empty;
  logic              m_src_getn;
  logic [WORD_W-1:0] m_dst;
  logic              m_dst_last;
  logic              m_dst_putn;
  logic              m_dst_full;

  modport engine (
    input  m_src, m_src_last, m_src_empty, m_dst_full,
    output m_src_getn, m_dst, m_dst_last, m_dst_putn
  );

  modport fifo (
    output m_src, m_src_last, m_src_empty, m_dst_full,
    input  m_src_getn, m_dst, m_dst_last, m_dst_putn
  );

endinterface

// File: rtl/m_copy_skid.sv
// Small synchronous FIFO between source pop and destination push; exposes occupancy so the
// engine can limit speculative pops.
module m_copy_skid
  import m_copy_pkg::*;
#(
  parameter int SKID_DEPTH = 2,
  parameter int CW         = $clog2(SKID_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_din,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic [CW-1:0]      o_count,
  output logic               o_empty
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [SKID_DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Storage array carries no reset; validity is tracked by the count alone.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (i_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (i_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/m_copy_engine.sv
// Copy/bypass engine: moves 65-bit words from the channel source FIFO to the destination FIFO.
// Define M_COPY_SWAP_EN to byte-reverse the data on its way to the destination.
module m_copy_engine
  import m_copy_pkg::*;
#(
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 m_reset,
  input  logic                 go,
  m_copy_if.engine             bus,
  output logic                 m_endn,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] wcnt
);

  localparam int CW = $clog2(SKID_DEPTH + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_pend;
  logic                 r_endn;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_wcnt;

  logic                 w_clr;
  logic                 w_go_ok;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_cap_last;
  logic [CW:0]          w_occ_eff;
  logic [ENTRY_W-1:0]   w_head;
  logic [CW-1:0]        w_skid_cnt;
  logic                 w_skid_empty;
  logic [WORD_W-1:0]    w_head_data;

  assign w_clr      = !wb_rst_i || m_reset;
  assign w_go_ok    = go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_cap_last = r_pend && bus.m_src_last;
  assign w_push     = !w_skid_empty && !bus.m_dst_full && !w_clr;

  // Occupancy after this cycle's push, plus the word already in flight from the source.
  assign w_occ_eff = {1'b0, w_skid_cnt} + {{CW{1'b0}}, r_pend} - {{CW{1'b0}}, w_push};

  assign w_pop = (r_state == ST_RUN) && !bus.m_src_empty && !w_cap_last && !w_clr &&
                 (w_occ_eff < (CW+1)'(SKID_DEPTH));

  m_copy_skid #(
    .SKID_DEPTH (SKID_DEPTH),
    .CW         (CW)
  ) u_skid (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_clr   (m_reset),
    .i_push  (r_pend),
    .i_din   ({bus.m_src_last, bus.m_src}),
    .i_pop   (w_push),
    .o_head  (w_head),
    .o_count (w_skid_cnt),
    .o_empty (w_skid_empty)
  );

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_go_ok) w_state_nxt = ST_RUN;   else w_state_nxt = ST_IDLE;
      ST_RUN:   if (w_cap_last) w_state_nxt = ST_DRAIN; else w_state_nxt = ST_RUN;
      ST_DRAIN: if (w_skid_empty && !r_pend) w_state_nxt = ST_DONE; else w_state_nxt = ST_DRAIN;
      ST_DONE:  if (w_go_ok) w_state_nxt = ST_RUN;   else w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pending read, word counter and status registers.
  always_ff @(posedge wb_clk_i) begin
    if (w_clr) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_wcnt  <= {CNT_WIDTH{1'b0}};
      r_endn  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pop;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      if (w_go_ok) begin
        r_wcnt <= {CNT_WIDTH{1'b0}};
      end else if (w_push) begin
        r_wcnt <= r_wcnt + CNT_WIDTH'(1);
      end else begin
        r_wcnt <= r_wcnt;
      end
      if (w_go_ok) begin
        r_endn <= 1'b1;
      end else if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) begin
        r_endn <= 1'b0;
      end else begin
        r_endn <= r_endn;
      end
    end
  end

  // Idle skid shows zero rather than stale storage.
  assign w_head_data = w_skid_empty ? {WORD_W{1'b0}} : w_head[WORD_W-1:0];

`ifdef M_COPY_SWAP_EN
  assign bus.m_dst = bswap64(w_head_data);
`else
  assign bus.m_dst = w_head_data;
`endif

  assign bus.m_dst_last = w_skid_empty ? 1'b0 : w_head[LAST_BIT];
  assign bus.m_src_getn = !w_pop;
  assign bus.m_dst_putn = !w_push;
  assign m_endn         = r_endn;
  assign busy           = r_busy;
  assign wcnt           = r_wcnt;

endmodule

// File: tb/tb_m_copy_engine.sv
// Directed bench for m_copy_engine with behavioural source/destination FIFO models.
module tb_m_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_reset;
  logic        go;
  logic        m_endn;
  logic        busy;
  logic [15:0] wcnt;

  int checks   = 0;
  int failures = 0;

  // Source FIFO model: initial block appends, model process consumes.
  logic [64:0] src_mem [256];
  int          src_wr = 0;
  int          src_rd = 0;
  int          pops   = 0;

  // Destination FIFO model records every accepted push.
  logic [64:0] dst_mem [256];
  int          dst_n  = 0;
  int          max_occ = 0;

  m_copy_if bus ();

  m_copy_engine #(.SKID_DEPTH(2), .CNT_WIDTH(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m_reset  (m_reset),
    .go       (go),
    .bus      (bus),
    .m_endn   (m_endn),
    .busy     (busy),
    .wcnt     (wcnt)
  );

  always #5 clk = ~clk;

  assign bus.m_src_empty = (src_rd == src_wr);

  always @(posedge clk) begin
    if (bus.m_src_getn === 1'b0 && src_rd != src_wr) begin
      bus.m_src      <= src_mem[src_rd & 255][63:0];
      bus.m_src_last <= src_mem[src_rd & 255][64];
      src_rd         <= src_rd + 1;
      pops           <= pops + 1;
    end
  end

  always @(posedge clk) begin
    if (bus.m_dst_putn === 1'b0) begin
      dst_mem[dst_n & 255] <= {bus.m_dst_last, bus.m_dst};
      dst_n                <= dst_n + 1;
    end
  end

  always @(negedge clk) begin
    if (int'(dut.w_skid_cnt) > max_occ) max_occ <= int'(dut.w_skid_cnt);
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] d, input logic l);
    src_mem[src_wr & 255] = {l, d};
    src_wr = src_wr + 1;
  endtask

  task automatic pulse_go();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (m_endn === 1'b0);
    end
  endtask

  initial begin
    bit          ok;
    int          base;
    int          pbase;
    int          k;
    logic [63:0] exp_swap;

    rst_n = 1'b0; m_reset = 1'b0; go = 1'b1; bus.m_dst_full = 1'b0;
    bus.m_src = 64'd0; bus.m_src_last = 1'b0;
    load(64'hDEAD_0000_0000_0001, 1'b0);
    load(64'hDEAD_0000_0000_0002, 1'b0);
    load(64'hDEAD_0000_0000_0003, 1'b1);

    // 1: reset with traffic present
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_getn",  {64'd0, bus.m_src_getn}, {64'd0, 1'b1});
    check("rst_putn",  {64'd0, bus.m_dst_putn}, {64'd0, 1'b1});
    check("rst_dst",   {bus.m_dst_last, bus.m_dst}, 65'd0);
    check("rst_endn",  {64'd0, m_endn}, {64'd0, 1'b1});
    check("rst_busy",  {64'd0, busy}, 65'd0);
    check("rst_wcnt",  {49'd0, wcnt}, 65'd0);
    check("rst_pops",  65'(pops), 65'd0);
    check("rst_push",  65'(dst_n), 65'd0);
    rst_n = 1'b1; go = 1'b0;
    src_wr = src_rd;

    // 2: eight-word stream
    @(negedge clk);
    base = dst_n; pbase = pops;
    for (int i = 0; i < 8; i++) load(64'h1000 + 64'(i), (i == 7));
    pulse_go();
    wait_done(100, ok);
    check("s2_done", {64'd0, ok}, {64'd0, 1'b1});
    check("s2_wcnt", {49'd0, wcnt}, 65'd8);
    check("s2_busy", {64'd0, busy}, 65'd0);
    check("s2_count", 65'(dst_n - base), 65'd8);
    check("s2_pops", 65'(pops - pbase), 65'd8);
    for (int i = 0; i < 8; i++)
      check("s2_word", dst_mem[(base + i) & 255], {(i == 7) ? 1'b1 : 1'b0, 64'h1000 + 64'(i)});

    // 3: 32 words with destination backpressure toggling every 3 cycles
    base = dst_n; pbase = pops;
    for (int i = 0; i < 32; i++) load(64'hB000_0000_0000_0000 + 64'(i), (i == 31));
    pulse_go();
    ok = 1'b0; k = 0;
    while (!ok && k < 400) begin
      @(negedge clk);
      k++;
      if (k % 3 == 0) bus.m_dst_full = ~bus.m_dst_full;
      ok = (m_endn === 1'b0);
    end
    bus.m_dst_full = 1'b0;
    check("bp_done", {64'd0, ok}, {64'd0, 1'b1});
    check("bp_wcnt", {49'd0, wcnt}, 65'd32);
    check("bp_count", 65'(dst_n - base), 65'd32);
    check("bp_pops", 65'(pops - pbase), 65'd32);
    check("bp_occ_le_depth", {64'd0, (max_occ <= 2)}, {64'd0, 1'b1});
    for (int i = 0; i < 32; i++)
      check("bp_word", dst_mem[(base + i) & 255],
            {(i == 31) ? 1'b1 : 1'b0, 64'hB000_0000_0000_0000 + 64'(i)});

    // 4: source starvation after go
    base = dst_n;
    pulse_go();
    repeat (10) @(negedge clk);
    check("st_busy", {64'd0, busy}, {64'd0, 1'b1});
    check("st_endn", {64'd0, m_endn}, {64'd0, 1'b1});
    check("st_getn", {64'd0, bus.m_src_getn}, {64'd0, 1'b1});
    load(64'h0000_0000_00C0_FFEE, 1'b1);
    wait_done(20, ok);
    check("st_done", {64'd0, ok}, {64'd0, 1'b1});
    check("st_wcnt", {49'd0, wcnt}, 65'd1);
    check("st_word", dst_mem[base & 255], {1'b1, 64'h0000_0000_00C0_FFEE});
    check("st_busy_end", {64'd0, busy}, 65'd0);

    // 5: m_reset pulse after four pushes of a sixteen-word stream
    base = dst_n;
    for (int i = 0; i < 16; i++) load(64'h5000 + 64'(i), (i == 15));
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = ((dst_n - base) >= 4);
      if (!ok) @(negedge clk);
    end
    check("mr_reach4", {64'd0, ok}, {64'd0, 1'b1});
    m_reset = 1'b1;
    @(negedge clk);
    m_reset = 1'b0;
    check("mr_busy", {64'd0, busy}, 65'd0);
    check("mr_endn", {64'd0, m_endn}, {64'd0, 1'b1});
    check("mr_wcnt", {49'd0, wcnt}, 65'd0);
    check("mr_putn", {64'd0, bus.m_dst_putn}, {64'd0, 1'b1});
    check("mr_dst", {bus.m_dst_last, bus.m_dst}, 65'd0);
    check("mr_count", 65'(dst_n - base), 65'd4);
    src_wr = src_rd;
    base = dst_n;
    for (int i = 0; i < 5; i++) load(64'h6000 + 64'(i), (i == 4));
    pulse_go();
    wait_done(100, ok);
    check("mr2_done", {64'd0, ok}, {64'd0, 1'b1});
    check("mr2_wcnt", {49'd0, wcnt}, 65'd5);
    check("mr2_first", dst_mem[base & 255], {1'b0, 64'h6000});
    check("mr2_last", dst_mem[(base + 4) & 255], {1'b1, 64'h6004});

    // 6: byte order on the destination
    base = dst_n;
`ifdef M_COPY_SWAP_EN
    exp_swap = 64'h0807060504030201;
`else
    exp_swap = 64'h0102030405060708;
`endif
    load(64'h0102030405060708, 1'b1);
    pulse_go();
    wait_done(30, ok);
    check("sw_done", {64'd0, ok}, {64'd0, 1'b1});
    check("sw_word", dst_mem[base & 255], {1'b1, exp_swap});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
